// File: rtl/irq_controller.sv
// Interrupt controller: latches NMI/timer pulses and a level external IRQ,
// arbitrates by fixed priority and hands one request at a time to the core.
module irq_controller #(
  parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nmi_pulse,
  input  logic        tmr_pulse,
  input  logic        ext_irq,
  input  logic        irq_en,
  input  logic [1:0]  irq_mask,
  input  logic        irq_ack,
  input  logic        irq_done,
  output logic        irq_req,
  output logic [1:0]  irq_cause,
  output logic [31:0] irq_vector,
  output logic        in_service,
  output logic [2:0]  pending
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SVC
  } state_t;

  state_t     state;
  logic       pend_nmi;
  logic       pend_tmr;
  logic       pend_ext;
  logic [2:0] elig;
  logic [1:0] win;
  logic       ack_hit;
  logic       clr_nmi;
  logic       clr_tmr;

  assign elig = {pend_ext & irq_en & irq_mask[1],
                 pend_tmr & irq_en & irq_mask[0],
                 pend_nmi};

  // Fixed priority: NMI > timer > external
  always_comb begin
    win = 2'd0;
    if (elig[0])      win = 2'd1;
    else if (elig[1]) win = 2'd2;
    else if (elig[2]) win = 2'd3;
  end

  assign ack_hit = (state == REQ) && irq_ack;
  assign clr_nmi = ack_hit && (irq_cause == 2'd1);
  assign clr_tmr = ack_hit && (irq_cause == 2'd2);

  assign pending = {pend_ext, pend_tmr, pend_nmi};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pend_nmi   <= 1'b0;
      pend_tmr   <= 1'b0;
      pend_ext   <= 1'b0;
      irq_req    <= 1'b0;
      in_service <= 1'b0;
      irq_cause  <= 2'd0;
      irq_vector <= VEC_BASE;
    end else begin
      // A new pulse on the clearing edge wins over the clear
      pend_nmi <= nmi_pulse | (pend_nmi & ~clr_nmi);
      pend_tmr <= tmr_pulse | (pend_tmr & ~clr_tmr);
      pend_ext <= ext_irq;
      unique case (state)
        IDLE: begin
          if (|elig) begin
            state      <= REQ;
            irq_req    <= 1'b1;
            irq_cause  <= win;
            irq_vector <= VEC_BASE + {28'd0, win, 2'b00};
          end
        end
        REQ: begin
          if (irq_ack) begin
            state      <= SVC;
            irq_req    <= 1'b0;
            in_service <= 1'b1;
          end
        end
        SVC: begin
          if (irq_done) begin
            state      <= IDLE;
            in_service <= 1'b0;
            irq_cause  <= 2'd0;
            irq_vector <= VEC_BASE;
          end
        end
        default: begin
          state      <= IDLE;
          irq_req    <= 1'b0;
          in_service <= 1'b0;
          irq_cause  <= 2'd0;
          irq_vector <= VEC_BASE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed vector table, corner sequences and
// random traffic against a behavioural model of the interrupt rules.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        nmi_pulse;
  logic        tmr_pulse;
  logic        ext_irq;
  logic        irq_en;
  logic [1:0]  irq_mask;
  logic        irq_ack;
  logic        irq_done;
  logic        irq_req;
  logic [1:0]  irq_cause;
  logic [31:0] irq_vector;
  logic        in_service;
  logic [2:0]  pending;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  irq_controller dut (
    .clk        (clk),
    .rst        (rst),
    .nmi_pulse  (nmi_pulse),
    .tmr_pulse  (tmr_pulse),
    .ext_irq    (ext_irq),
    .irq_en     (irq_en),
    .irq_mask   (irq_mask),
    .irq_ack    (irq_ack),
    .irq_done   (irq_done),
    .irq_req    (irq_req),
    .irq_cause  (irq_cause),
    .irq_vector (irq_vector),
    .in_service (in_service),
    .pending    (pending)
  );

  // Model: pending flags, phase (0 idle, 1 requesting, 2 serving), cause
  bit       m_nmi, m_tmr, m_ext;
  int       m_phase = 0;
  bit [1:0] m_cause = 0;

  typedef struct {
    bit       r, n, t, e, en;
    bit [1:0] m;
    bit       a, d;
    bit       x_req;
    bit       x_svc;
    bit [1:0] x_cause;
    bit [2:0] x_pend;
    bit [31:0] x_vec;
  } vec_t;

  vec_t tbl[13];

  function automatic logic [38:0] obs();
    return {irq_req, in_service, irq_cause, pending, irq_vector};
  endfunction

  function automatic logic [38:0] model_out();
    logic [31:0] v;
    v = 32'h100 + 32'(m_cause) * 4;
    return {m_phase == 1, m_phase == 2, m_cause, {m_ext, m_tmr, m_nmi}, v};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    bit       nmi_ok, tmr_ok, ext_ok;
    bit       take_n, take_t;
    if (rst) begin
      m_nmi = 0; m_tmr = 0; m_ext = 0;
      m_phase = 0; m_cause = 0;
      return;
    end
    nmi_ok = m_nmi;
    tmr_ok = m_tmr && irq_en && irq_mask[0];
    ext_ok = m_ext && irq_en && irq_mask[1];
    take_n = (m_phase == 1) && irq_ack && (m_cause == 1);
    take_t = (m_phase == 1) && irq_ack && (m_cause == 2);
    if (m_phase == 0) begin
      if (nmi_ok)      begin m_phase = 1; m_cause = 1; end
      else if (tmr_ok) begin m_phase = 1; m_cause = 2; end
      else if (ext_ok) begin m_phase = 1; m_cause = 3; end
    end else if (m_phase == 1) begin
      if (irq_ack) m_phase = 2;
    end else begin
      if (irq_done) begin m_phase = 0; m_cause = 0; end
    end
    m_nmi = nmi_pulse || (m_nmi && !take_n);
    m_tmr = tmr_pulse || (m_tmr && !take_t);
    m_ext = ext_irq;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("model", 64'(obs()), 64'(model_out()));
  endtask

  task automatic drive(input bit r, input bit n, input bit t, input bit e,
                       input bit en, input bit [1:0] m, input bit a,
                       input bit d);
    rst = r; nmi_pulse = n; tmr_pulse = t; ext_irq = e;
    irq_en = en; irq_mask = m; irq_ack = a; irq_done = d;
  endtask

  task automatic wait_req(input string name);
    bit got;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      got = irq_req;
    end
    chk({name, "_req_timeout"}, 64'(got), 64'd1);
  endtask

  function automatic vec_t mk(bit r, bit n, bit t, bit e, bit en, bit [1:0] m,
                              bit a, bit d, bit xr, bit xs, bit [1:0] xc,
                              bit [2:0] xp, bit [31:0] xv);
    vec_t v;
    v.r = r; v.n = n; v.t = t; v.e = e; v.en = en; v.m = m;
    v.a = a; v.d = d; v.x_req = xr; v.x_svc = xs; v.x_cause = xc;
    v.x_pend = xp; v.x_vec = xv;
    return v;
  endfunction

  initial begin
    bit seen;
    bit ext_lvl;
    //           r n t e en m     a d  req svc cause pend    vector
    tbl[0]  = mk(1,0,0,0,0,2'b00,0,0, 0,0,2'd0,3'b000,32'h100);
    tbl[1]  = mk(0,0,1,0,1,2'b01,0,0, 0,0,2'd0,3'b010,32'h100);
    tbl[2]  = mk(0,0,0,0,1,2'b01,0,0, 1,0,2'd2,3'b010,32'h108);
    tbl[3]  = mk(0,0,0,0,1,2'b01,1,0, 0,1,2'd2,3'b000,32'h108);
    tbl[4]  = mk(0,0,0,0,1,2'b01,0,0, 0,1,2'd2,3'b000,32'h108);
    tbl[5]  = mk(0,0,0,0,1,2'b01,0,1, 0,0,2'd0,3'b000,32'h100);
    tbl[6]  = mk(0,1,1,0,1,2'b01,0,0, 0,0,2'd0,3'b011,32'h100);
    tbl[7]  = mk(0,0,0,0,1,2'b01,0,0, 1,0,2'd1,3'b011,32'h104);
    tbl[8]  = mk(0,0,0,0,1,2'b01,1,0, 0,1,2'd1,3'b010,32'h104);
    tbl[9]  = mk(0,0,0,0,1,2'b01,0,1, 0,0,2'd0,3'b010,32'h100);
    tbl[10] = mk(0,0,0,0,1,2'b01,0,0, 1,0,2'd2,3'b010,32'h108);
    tbl[11] = mk(0,0,0,0,1,2'b01,1,0, 0,1,2'd2,3'b000,32'h108);
    tbl[12] = mk(0,0,0,0,1,2'b01,0,1, 0,0,2'd0,3'b000,32'h100);

    drive(1,0,0,0,0,2'b00,0,0);
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].r, tbl[i].n, tbl[i].t, tbl[i].e, tbl[i].en, tbl[i].m,
            tbl[i].a, tbl[i].d);
      step();
      chk($sformatf("tbl%0d", i), 64'(obs()),
          64'({tbl[i].x_req, tbl[i].x_svc, tbl[i].x_cause, tbl[i].x_pend,
               tbl[i].x_vec}));
    end

    // Timer held off by global enable, then released
    drive(0,0,1,0,0,2'b01,0,0);
    step();
    drive(0,0,0,0,0,2'b01,0,0);
    seen = 0;
    repeat (20) begin
      step();
      if (irq_req) seen = 1;
    end
    chk("gated_noreq", 64'(seen), 64'd0);
    chk("gated_pend", 64'(pending[1]), 64'd1);
    drive(0,0,0,0,1,2'b01,0,0);
    wait_req("enable");
    chk("enable_cause", 64'(irq_cause), 64'd2);
    drive(0,0,0,0,1,2'b01,1,0); step();
    drive(0,0,0,0,1,2'b01,0,1); step();

    // External level held through done re-requests at done+2
    drive(0,0,0,1,1,2'b10,0,0);
    wait_req("ext");
    chk("ext_cause", 64'(irq_cause), 64'd3);
    chk("ext_vec", 64'(irq_vector), 64'h10c);
    drive(0,0,0,1,1,2'b10,1,0); step();
    drive(0,0,0,1,1,2'b10,0,0); step();
    drive(0,0,0,1,1,2'b10,0,1); step();
    chk("ext_idle", 64'({irq_req, in_service, irq_cause}), 64'd0);
    drive(0,0,0,1,1,2'b10,0,0); step();
    chk("ext_rereq", 64'({irq_req, irq_cause}), 64'b111);
    drive(0,0,0,0,1,2'b10,1,0); step();
    drive(0,0,0,0,1,2'b10,0,0); step();
    drive(0,0,0,0,1,2'b10,0,1); step();
    drive(0,0,0,0,1,2'b10,0,0);
    seen = 0;
    repeat (5) begin
      step();
      if (irq_req) seen = 1;
    end
    chk("ext_dropped", 64'(seen), 64'd0);

    // Timer pulse on the ack edge survives the clear
    drive(0,0,1,0,1,2'b01,0,0); step();
    drive(0,0,0,0,1,2'b01,0,0);
    wait_req("tmr2");
    drive(0,0,1,0,1,2'b01,1,0); step();
    chk("setwins_pend", 64'(pending[1]), 64'd1);
    chk("setwins_svc", 64'(in_service), 64'd1);
    drive(0,0,0,0,1,2'b01,0,0); step();
    drive(0,0,0,0,1,2'b01,0,1); step();
    drive(0,0,0,0,1,2'b01,0,0); step();
    chk("setwins_rereq", 64'({irq_req, irq_cause}), 64'b110);
    drive(0,0,0,0,1,2'b01,1,0); step();
    drive(0,0,0,0,1,2'b01,0,1); step();

    // Reset mid-service, then spurious ack/done while idle
    drive(0,1,0,0,0,2'b00,0,0); step();
    drive(0,0,0,0,0,2'b00,0,0);
    wait_req("nmi");
    drive(0,0,0,0,0,2'b00,1,0); step();
    chk("svc_before_rst", 64'(in_service), 64'd1);
    drive(1,0,0,0,0,2'b00,0,0); step();
    chk("rst_svc", 64'(obs()), 64'({7'd0, 32'h100}));
    for (int i = 0; i < 3; i++) begin
      drive(0,0,0,0,1,2'b11,1,1); step();
      chk($sformatf("spurious%0d", i), 64'(obs()), 64'({7'd0, 32'h100}));
    end

    // Random traffic against the model
    ext_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) ext_lvl = !ext_lvl;
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 11) == 0,
            ext_lvl,
            $urandom_range(0, 3) != 0,
            2'($urandom_range(0, 3)),
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
